// File: rtl/stochastic_decoder.sv
// stochastic_decoder
//   Counts the 1s of a unipolar stochastic bitstream over a window of nummax
//   valid bits, giving count_out/nummax_out = P(bit=1). One window per start
//   pulse; the result is held until the next window completes.
// Ports
//   clk        in  1  system clock, rising edge
//   rst        in  1  synchronous active-high reset
//   start      in  1  begin a new window (sampled only when idle)
//   nummax     in  W  window length in valid bits, latched on accepted start
//   bit_in     in  1  stochastic stream bit
//   bit_valid  in  1  qualifier for bit_in
//   busy       out 1  high while a window is being accumulated
//   done       out 1  one-cycle pulse when count_out/nummax_out update
//   count_out  out W  ones seen in the last completed window
//   nummax_out out W  length of the last completed window
module stochastic_decoder #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] nummax,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] count_out,
  output logic [W-1:0] nummax_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_next;
  logic [W-1:0] len, ones, seen;

  logic         accept;      // start taken with a non-empty window
  logic         empty_start; // start with nummax==0: completes immediately
  logic         last_bit;    // this edge accepts bit number len
  logic         done_next;
  logic [W-1:0] count_next;
  logic [W-1:0] nummax_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    accept      = 1'b0;
    empty_start = 1'b0;
    last_bit    = 1'b0;
    state_next  = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (nummax != '0) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            empty_start = 1'b1;
          end
        end
      end
      RUN: begin
        // seen < len always holds in RUN, so len-1 never underflows here
        if (bit_valid && (seen == len - W'(1))) begin
          last_bit   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: values to be registered into the result outputs
  always_comb begin
    done_next   = 1'b0;
    count_next  = '0;
    nummax_next = '0;
    if (empty_start) begin
      done_next = 1'b1;
    end else if (last_bit) begin
      done_next   = 1'b1;
      count_next  = ones + W'(bit_in);
      nummax_next = len;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      len        <= '0;
      ones       <= '0;
      seen       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count_out  <= '0;
      nummax_out <= '0;
    end else begin
      busy <= (state_next == RUN);
      done <= done_next;
      if (done_next) begin
        count_out  <= count_next;
        nummax_out <= nummax_next;
      end
      if (accept) begin
        len  <= nummax;
        ones <= '0;
        seen <= '0;
      end else if ((state == RUN) && bit_valid) begin
        ones <= ones + W'(bit_in);
        seen <= seen + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stochastic_decoder.sv
// tb_stochastic_decoder
//   Directed and randomized windows for stochastic_decoder, checked against a
//   window-level model: expected count is the number of 1s among the first
//   nummax valid bits driven after start.
module tb_stochastic_decoder;
  localparam int unsigned W = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] nummax;
  logic         bit_in;
  logic         bit_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] count_out;
  logic [W-1:0] nummax_out;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned held_count = 0;
  int unsigned held_len   = 0;
  bit          pat[$];

  stochastic_decoder #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .nummax     (nummax),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .count_out  (count_out),
    .nummax_out (nummax_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles: no start, random bus activity that must be ignored.
  task automatic idle(input int unsigned cycles);
    start = 1'b0;
    repeat (cycles) begin
      bit_valid = 1'($urandom_range(1, 0));
      bit_in    = 1'($urandom_range(1, 0));
      tick();
      check("idle_done",  32'(done),       0);
      check("idle_busy",  32'(busy),       0);
      check("idle_count", 32'(count_out),  held_count);
      check("idle_len",   32'(nummax_out), held_len);
    end
  endtask

  // One window of n valid bits. Bits come from pat first, then random with
  // p_one percent ones; p_gap percent of cycles are invalid and carry 1s.
  // With hold, start stays high and nummax switches to alt during the run.
  task automatic window(input int unsigned n, input int unsigned p_one,
                        input int unsigned p_gap, input bit hold,
                        input logic [W-1:0] alt);
    int unsigned got = 0;
    int unsigned exp_ones = 0;
    bit v;
    bit b;
    start     = 1'b1;
    nummax    = n[W-1:0];
    bit_valid = 1'($urandom_range(1, 0));
    bit_in    = 1'($urandom_range(1, 0));
    tick();
    if (hold) nummax = alt;
    else start = 1'b0;
    if (n == 0) begin
      check("zero_busy",  32'(busy),       0);
      check("zero_done",  32'(done),       1);
      check("zero_count", 32'(count_out),  0);
      check("zero_len",   32'(nummax_out), 0);
      held_count = 0;
      held_len   = 0;
      return;
    end
    check("start_busy", 32'(busy), 1);
    check("start_done", 32'(done), 0);
    while (got < n) begin
      v = ($urandom_range(99, 0) >= p_gap);
      if (!v) b = 1'b1;
      else if (pat.size() > 0) b = pat.pop_front();
      else b = ($urandom_range(99, 0) < p_one);
      bit_valid = v;
      bit_in    = b;
      if (v) begin
        got++;
        exp_ones += 32'(b);
      end
      tick();
      if (got < n) begin
        check("run_busy", 32'(busy),      1);
        check("run_done", 32'(done),      0);
        check("run_held", 32'(count_out), held_count);
      end
    end
    held_count = exp_ones;
    held_len   = n;
    bit_valid  = 1'b0;
    check("end_done",  32'(done),       1);
    check("end_busy",  32'(busy),       0);
    check("end_count", 32'(count_out),  exp_ones);
    check("end_len",   32'(nummax_out), n);
  endtask

  initial begin
    // Reset with start asserted: reset must win
    rst = 1'b1; start = 1'b1; nummax = 9'd5; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    tick();
    check("rst_busy",  32'(busy),       0);
    check("rst_done",  32'(done),       0);
    check("rst_count", 32'(count_out),  0);
    check("rst_len",   32'(nummax_out), 0);
    rst = 1'b0;
    idle(2);

    // Fixed 8-bit pattern, four ones
    pat = '{1, 0, 1, 1, 0, 0, 1, 0};
    window(8, 50, 0, 1'b0, '0);
    idle(2);

    // 10 valid bits with invalid cycles carrying 1s
    pat = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    window(10, 50, 35, 1'b0, '0);
    idle(1);

    // Empty window
    window(0, 50, 0, 1'b0, '0);
    idle(2);

    // Maximum window: all ones then all zeros
    window(511, 100, 0, 1'b0, '0);
    idle(1);
    window(511, 0, 0, 1'b0, '0);
    idle(1);
    window(511, 100, 0, 1'b0, '0);

    // Reset in the middle of a window discards it and clears the result
    start = 1'b1; nummax = 9'd8;
    tick();
    start = 1'b0;
    repeat (5) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom_range(1, 0));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; bit_valid = 1'b0;
    check("mrst_busy",  32'(busy),       0);
    check("mrst_done",  32'(done),       0);
    check("mrst_count", 32'(count_out),  0);
    check("mrst_len",   32'(nummax_out), 0);
    held_count = 0;
    held_len   = 0;
    idle(1);
    pat = '{1, 1, 1, 1};
    window(4, 50, 0, 1'b0, '0);
    idle(1);

    // start held and nummax changed mid-run; start on the done cycle is taken
    window(6, 50, 0, 1'b1, 9'd3);
    window(3, 50, 0, 1'b0, '0);
    idle(2);

    // Randomized windows, sometimes back-to-back
    for (int i = 0; i < 16; i++) begin
      window($urandom_range(24, 0), $urandom_range(100, 0),
             $urandom_range(50, 0), 1'b0, '0);
      if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
